// File: rtl/demux_rr_sched_pkg.sv
// demux_rr_sched_pkg: shared FSM encoding and sizing for the round-robin demux scheduler
package demux_rr_sched_pkg;
  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;
  localparam int NCH = 4;
  localparam int CNT_W = 16;
endpackage

// File: rtl/demux_rr_sched_if.sv
// demux_rr_sched_if: upstream word, per-channel handshake, select and transfer count; slave=scheduler, master=environment
interface demux_rr_sched_if #(parameter int WIDTH = 8);
  import demux_rr_sched_pkg::*;
  logic in_valid;
  logic [WIDTH-1:0] in_data;
  logic in_ready;
  logic [NCH-1:0] en_mask;
  logic [NCH-1:0] out_ready;
  logic [NCH-1:0] out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0] sel;
  logic [CNT_W-1:0] xfer_cnt;
  modport slave (input in_valid, in_data, en_mask, out_ready,
                 output in_ready, out_valid, out_data, sel, xfer_cnt);
  modport master (output in_valid, in_data, en_mask, out_ready,
                  input in_ready, out_valid, out_data, sel, xfer_cnt);
endinterface

// File: rtl/rr_next_sel.sv
// rr_next_sel: first enabled channel at or after ptr (ascending, wrapping); ports ptr, mask -> idx, found
module rr_next_sel
  import demux_rr_sched_pkg::*;
(
  input  logic [1:0]     ptr,
  input  logic [NCH-1:0] mask,
  output logic [1:0]     idx,
  output logic           found
);
  always_comb begin
    idx = ptr;
    found = 1'b0;
    // scan farthest offset first so the nearest enabled channel wins
    for (int i = NCH - 1; i >= 0; i--)
      if (mask[2'(ptr + 2'(i))]) begin
        idx = 2'(ptr + 2'(i));
        found = 1'b1;
      end
  end
endmodule

// File: rtl/demux_rr_sched.sv
// demux_rr_sched: 1-to-4 round-robin demux; ports clk, rst (async high), b (slave bus); `DEMUX_SKIP_EN` skips a stalled channel
module demux_rr_sched
  import demux_rr_sched_pkg::*;
#(parameter int WIDTH = 8)
(
  input logic clk,
  input logic rst,
  demux_rr_sched_if.slave b
);
  state_t state, state_n;
  logic [1:0] ptr, sel, first_idx;
  logic first_found, acc, done;
  logic [WIDTH-1:0] hold;
  logic [CNT_W-1:0] cnt;
  rr_next_sel u_first (.ptr(ptr), .mask(b.en_mask), .idx(first_idx), .found(first_found));
`ifdef DEMUX_SKIP_EN
  logic [1:0] skip_idx;
  logic skip_found;
  rr_next_sel u_skip (.ptr(2'(sel + 2'd1)), .mask(b.en_mask), .idx(skip_idx), .found(skip_found));
`endif
  always_comb begin
    acc = (state == IDLE) && b.in_valid && first_found;
    done = (state == HOLD) && b.out_ready[sel];
    state_n = acc ? HOLD : done ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      sel <= '0;
      hold <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      if (acc) begin
        hold <= b.in_data;
        sel <= first_idx;
      end
      if (done) begin
        ptr <= 2'(sel + 2'd1);
        cnt <= cnt + 1'b1;
      end
`ifdef DEMUX_SKIP_EN
      else if (state == HOLD && skip_found) sel <= skip_idx;
`endif
    end
  assign b.in_ready = !rst && (state == IDLE) && first_found;
  assign b.out_valid = {3'b000, state == HOLD} << sel;
  assign b.out_data = hold;
  assign b.sel = sel;
  assign b.xfer_cnt = cnt;
endmodule
